// File: rtl/switch_enter_capture.sv
`default_nettype none
// ============================================================================
//  Module   : switch_enter_capture
//  Brief    : Synchronises and debounces a data-switch bank plus an enter
//             switch; each qualified enter edge pushes the debounced data word
//             into a show-ahead FIFO drained by the CPU, with a sticky
//             overflow flag for dropped entries.
//  Revision : 1.0 - initial release
// ============================================================================
module switch_enter_capture #(
   parameter int DATA_WIDTH         = 16,
   parameter int DEPTH              = 4,
   parameter int DEBOUNCE_CYCLES    = 16,
   parameter int CAPTURE_ON_RELEASE = 0
) (
   input  logic                           clock_i,
   input  logic                           reset_i,
   input  logic [DATA_WIDTH-1:0]          sw_data_i,
   input  logic                           sw_enter_i,
   input  logic                           rd_en_i,
   input  logic                           clr_ovf_i,
   output logic [DATA_WIDTH-1:0]          rd_data_o,
   output logic                           valid_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o,
   output logic                           overflow_o,
   output logic                           enter_level_o,
   output logic [DATA_WIDTH-1:0]          data_level_o
);

   // Enter switch travels as the MSB of the synchronised vector.
   localparam int c_VEC_W = DATA_WIDTH + 1;
   localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_OCC_W = $clog2(DEPTH + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(DEPTH);

   // Synchroniser and debouncer state
   logic [c_VEC_W-1:0]    sync1_q, sync2_q, prev_q;
   logic [c_VEC_W-1:0]    stable_q, stable_d;
   logic [c_CNT_W-1:0]    cnt_q, cnt_d;
   logic                  armed_q, armed_d;
   logic                  enter_dly_q, enter_dly_d;

   // FIFO state
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [c_OCC_W-1:0]    count_q, count_d;
   logic                  ovf_q, ovf_d;

   // Combinational control
   logic                  same;
   logic                  load;
   logic                  enter_lvl;
   logic [DATA_WIDTH-1:0] data_lvl;
   logic                  cap_evt;
   logic                  pop;
   logic                  full;
   logic                  wr;
   logic                  drop;

   assign enter_lvl = stable_q[c_VEC_W-1];
   assign data_lvl  = stable_q[DATA_WIDTH-1:0];

   // Debounce qualification, arming and capture-edge detection
   always_comb begin
      same        = (sync2_q == prev_q);
      load        = same && (cnt_q == c_CNT_MAX);
      cnt_d       = cnt_q;
      stable_d    = stable_q;
      armed_d     = armed_q;
      enter_dly_d = enter_dly_q;
      if (!same) begin
         cnt_d = '0;
      end else if (cnt_q != c_CNT_MAX) begin
         cnt_d = cnt_q + c_CNT_W'(1);
      end
      if (load) begin
         stable_d = sync2_q;
      end
      // Until the first qualified load the edge reference tracks the value
      // being loaded, so a switch already on at reset produces no entry.
      if (armed_q) begin
         enter_dly_d = enter_lvl;
      end else if (load) begin
         armed_d     = 1'b1;
         enter_dly_d = sync2_q[c_VEC_W-1];
      end
      if (CAPTURE_ON_RELEASE != 0) begin
         cap_evt = armed_q && enter_dly_q && !enter_lvl;
      end else begin
         cap_evt = armed_q && !enter_dly_q && enter_lvl;
      end
   end

   // FIFO push/pop arbitration, occupancy and overflow
   always_comb begin
      pop      = rd_en_i && (count_q != '0);
      full     = (count_q == c_FULL);
      wr       = cap_evt && (!full || pop);
      drop     = cap_evt && full && !pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (wr) begin
         wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      end
      if (wr && !pop) begin
         count_d = count_q + c_OCC_W'(1);
      end else if (pop && !wr) begin
         count_d = count_q - c_OCC_W'(1);
      end
      // A drop in the same cycle as a clear request leaves the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf_i) begin
         ovf_d = 1'b0;
      end
   end

   // Control and status registers
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         prev_q      <= '0;
         cnt_q       <= '0;
         stable_q    <= '0;
         armed_q     <= 1'b0;
         enter_dly_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         sync1_q     <= {sw_enter_i, sw_data_i};
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         cnt_q       <= cnt_d;
         stable_q    <= stable_d;
         armed_q     <= armed_d;
         enter_dly_q <= enter_dly_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
      end
   end

   // FIFO storage; contents need no reset because the output is masked by valid
   always_ff @(posedge clock_i) begin
      if (wr) begin
         mem_q[wr_ptr_q] <= data_lvl;
      end
   end

   assign valid_o       = (count_q != '0);
   assign rd_data_o     = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o       = count_q;
   assign overflow_o    = ovf_q;
   assign enter_level_o = enter_lvl;
   assign data_level_o  = data_lvl;

endmodule
`default_nettype wire

// File: tb/tb_switch_enter_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_enter_capture
//  Brief    : Self-checking bench for switch_enter_capture. Two instances
//             (capture on press and on release) share the same stimulus and
//             are compared every cycle against a sample-history model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_switch_enter_capture;

   localparam int W   = 16;
   localparam int D   = 4;
   localparam int DB  = 4;
   localparam int MAX = DB - 1;
   localparam int OW  = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  sw_data;
   logic          sw_enter;
   logic          rd_en;
   logic          clr_ovf;

   logic [W-1:0]  rd_data  [2];
   logic          valid    [2];
   logic [OW-1:0] count    [2];
   logic          overflow [2];
   logic          e_lvl    [2];
   logic [W-1:0]  d_lvl    [2];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   switch_enter_capture #(
      .DATA_WIDTH(W), .DEPTH(D), .DEBOUNCE_CYCLES(DB), .CAPTURE_ON_RELEASE(0)
   ) u_press (
      .clock_i(clk), .reset_i(rst), .sw_data_i(sw_data), .sw_enter_i(sw_enter),
      .rd_en_i(rd_en), .clr_ovf_i(clr_ovf), .rd_data_o(rd_data[0]),
      .valid_o(valid[0]), .count_o(count[0]), .overflow_o(overflow[0]),
      .enter_level_o(e_lvl[0]), .data_level_o(d_lvl[0])
   );

   switch_enter_capture #(
      .DATA_WIDTH(W), .DEPTH(D), .DEBOUNCE_CYCLES(DB), .CAPTURE_ON_RELEASE(1)
   ) u_release (
      .clock_i(clk), .reset_i(rst), .sw_data_i(sw_data), .sw_enter_i(sw_enter),
      .rd_en_i(rd_en), .clr_ovf_i(clr_ovf), .rd_data_o(rd_data[1]),
      .valid_o(valid[1]), .count_o(count[1]), .overflow_o(overflow[1]),
      .enter_level_o(e_lvl[1]), .data_level_o(d_lvl[1])
   );

   // Reference model: raw-sample history since reset, debounced level,
   // edge reference, and one entry queue per instance.
   int           n_edges;
   int           base;
   logic [W:0]   hq [$];
   logic [W:0]   m_lvl;
   logic         m_armed;
   logic         m_ref;
   logic [W-1:0] mq [2][$];
   logic         m_ovf [2];

   // Raw {enter,data} sampled at edge k after reset; earlier samples read as 0.
   function automatic logic [W:0] h(input int k);
      if (k <= 0) return '0;
      return hq[k - base - 1];
   endfunction

   // Event the next edge would see for the press-capturing instance.
   function automatic logic press_pending();
      return m_armed && !m_ref && m_lvl[W];
   endfunction

   task automatic model_edge(input logic r, input logic [W:0] raw,
                             input logic rd, input logic clr);
      logic       load;
      logic [W:0] s2v;
      logic       evt [2];
      logic       pop, full;
      if (r) begin
         n_edges = 0;
         base    = 0;
         hq.delete();
         m_lvl   = '0;
         m_armed = 1'b0;
         m_ref   = 1'b0;
         for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            m_ovf[m] = 1'b0;
         end
         return;
      end
      n_edges++;
      hq.push_back(raw);
      if (hq.size() > MAX + 8) begin
         hq.delete(0);
         base++;
      end
      // A sample is qualified once MAX+2 consecutive synchronised samples agree
      // and at least MAX edges have passed since reset.
      s2v  = h(n_edges - 2);
      load = (n_edges >= MAX + 1);
      for (int k = n_edges - MAX - 3; k <= n_edges - 2; k++) begin
         if (h(k) != s2v) load = 1'b0;
      end
      evt[0] = m_armed && !m_ref && m_lvl[W];
      evt[1] = m_armed && m_ref && !m_lvl[W];
      for (int m = 0; m < 2; m++) begin
         pop  = rd && (mq[m].size() > 0);
         full = (mq[m].size() == D);
         if (pop) mq[m].delete(0);
         if (evt[m] && (!full || pop)) mq[m].push_back(m_lvl[W-1:0]);
         if (evt[m] && full && !pop) m_ovf[m] = 1'b1;
         else if (clr) m_ovf[m] = 1'b0;
      end
      if (m_armed) begin
         m_ref = m_lvl[W];
      end else if (load) begin
         m_ref   = s2v[W];
         m_armed = 1'b1;
      end
      if (load) m_lvl = s2v;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [W-1:0] exp_rd;
      for (int m = 0; m < 2; m++) begin
         exp_rd = (mq[m].size() > 0) ? mq[m][0] : '0;
         chk($sformatf("rd_data[%0d]", m),  32'(rd_data[m]),  32'(exp_rd));
         chk($sformatf("valid[%0d]", m),    32'(valid[m]),    32'(mq[m].size() > 0));
         chk($sformatf("count[%0d]", m),    32'(count[m]),    32'(mq[m].size()));
         chk($sformatf("overflow[%0d]", m), 32'(overflow[m]), 32'(m_ovf[m]));
         chk($sformatf("enter_lvl[%0d]", m), 32'(e_lvl[m]),   32'(m_lvl[W]));
         chk($sformatf("data_lvl[%0d]", m), 32'(d_lvl[m]),    32'(m_lvl[W-1:0]));
      end
   endtask

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic cyc(input logic r, input logic [W-1:0] data, input logic ent,
                      input logic rd, input logic clr);
      rst      = r;
      sw_data  = data;
      sw_enter = ent;
      rd_en    = rd;
      clr_ovf  = clr;
      @(posedge clk);
      model_edge(r, {ent, data}, rd, clr);
      #1;
      check_outputs();
   endtask

   task automatic hold(input logic [W-1:0] data, input logic ent, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, data, ent, 1'b0, 1'b0);
   endtask

   task automatic press(input logic [W-1:0] data);
      hold(data, 1'b1, 8);
      hold(data, 1'b0, 8);
   endtask

   initial begin
      logic [W-1:0] rdata;
      logic         rent;
      int           left;

      // Reset, then a single press with data 1 and a pop.
      repeat (3) cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
      hold(16'h0001, 1'b1, 9);
      cyc(1'b0, 16'h0001, 1'b1, 1'b1, 1'b0);
      hold(16'h0001, 1'b1, 2);
      hold(16'h0001, 1'b0, 10);

      // Bouncing enter, then a real press with 0x00A5.
      cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         hold(16'h00A5, 1'b1, 2);
         hold(16'h00A5, 1'b0, 2);
      end
      hold(16'h00A5, 1'b1, 12);
      hold(16'h00A5, 1'b0, 10);

      // Enter held across reset release, then a clean press with 3.
      hold(16'h0000, 1'b1, 3);
      cyc(1'b1, '0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, '0, 1'b1, 1'b0, 1'b0);
      hold(16'h0000, 1'b1, 12);
      hold(16'h0000, 1'b0, 10);
      press(16'h0003);

      // Five presses without reads: overflow, drain, clear.
      cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
      for (int v = 1; v <= 5; v++) press(W'(v));
      for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      hold('0, 1'b0, 2);

      // Full FIFO with a pop landing on the push edge.
      cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
      for (int v = 1; v <= 4; v++) press(W'(v + 16));
      for (int i = 0; i < 12; i++) cyc(1'b0, 16'h0009, 1'b1, press_pending(), 1'b0);
      hold(16'h0009, 1'b0, 10);

      // Reset with three entries queued.
      cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
      for (int v = 1; v <= 3; v++) press(W'(v + 32));
      cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
      hold('0, 1'b0, 3);

      // Randomised switch activity with glitches, reads, clears and resets.
      rdata = '0;
      rent  = 1'b0;
      left  = 0;
      for (int i = 0; i < 3000; i++) begin
         if (left == 0) begin
            if ($urandom_range(0, 9) < 6) rent = ~rent;
            if ($urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 1) == 1) rdata = W'($urandom);
               else rdata[$urandom_range(0, W - 1)] ^= 1'b1;
            end
            left = $urandom_range(1, 9);
         end
         left--;
         cyc(($urandom_range(0, 399) == 0), rdata, rent,
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
